// File: rtl/imem_sync_pkg.sv
// Shared types and constants for the pipelined instruction memory.
// Fault classification lives here so fetch-side units can reuse it.
package imem_sync_pkg;

   localparam int XLEN            = 32;
   localparam int IMEM_SIZE       = 1024;
   localparam int WORD_ADDR_WIDTH = $clog2(IMEM_SIZE);
   localparam int FETCH_MAX       = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2
   } imem_fault_e;

   typedef struct packed {
      logic [XLEN-1:0]           addr;
      logic [FETCH_MAX*XLEN-1:0] instr;
      imem_fault_e               fault;
   } imem_resp_t;

   // The full word index (addr >> 2) folds the "upper bits nonzero" case into the bound check.
   function automatic imem_fault_e imem_classify(input logic [XLEN-1:0] addr,
                                                 input int depth,
                                                 input int fetch_w);
      logic [XLEN-1:0] last;
      if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
      last = (addr >> 2) + XLEN'(fetch_w - 1);
      if (last >= XLEN'(depth)) return FAULT_RANGE;
      return FAULT_NONE;
   endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Small synchronous response FIFO; clear drops every entry at the next edge.
// Storage is not reset: consumers must qualify head with !empty.
module imem_resp_fifo
   import imem_sync_pkg::*;
#(
   parameter type entry_t = imem_resp_t,
   parameter int  DEPTH   = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clear,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output logic   empty,
   output entry_t head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t          store [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     cnt;
   logic            push_ok, pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_ok = push && (cnt != (PW+1)'(DEPTH));
   assign pop_ok  = pop && (cnt != '0);
   assign empty   = (cnt == '0);
   assign head    = store[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         cnt <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clear) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/imem_sync.sv
// Pipelined instruction memory: byte-addressed fetch in, FETCH_WIDTH words out
// LATENCY cycles later, with credit-based backpressure, flush and a preload port.
module imem_sync
   import imem_sync_pkg::*;
#(
   parameter int    DEPTH       = IMEM_SIZE,
   parameter int    FETCH_WIDTH = 1,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [XLEN-1:0]             req_addr,
   input  logic                        flush,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [XLEN-1:0]             resp_addr,
   output logic [FETCH_WIDTH*XLEN-1:0] resp_instr,
   output logic [1:0]                  resp_fault,
   input  logic                        ld_en,
   input  logic [WORD_ADDR_WIDTH-1:0]  ld_addr,
   input  logic [XLEN-1:0]             ld_data
);

   localparam int FIFO_DEPTH = LATENCY + 1;
   localparam int IW         = $clog2(DEPTH);
   localparam int CW         = $clog2(LATENCY + 2);

   typedef struct packed {
      logic [XLEN-1:0]                  addr;
      logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
      imem_fault_e                      fault;
   } resp_t;

   logic [XLEN-1:0] mem [DEPTH];

   logic          acc, pop, push_vld, fifo_empty;
   logic [CW-1:0] cnt;
   logic [IW-1:0] lane_idx;
   resp_t         new_ent, push_ent, head;

   // Preload writes land at the edge, so a same-cycle fetch still sees the old word.
   always_ff @(posedge clk) begin
      if (ld_en && ({1'b0, ld_addr} < (WORD_ADDR_WIDTH+1)'(DEPTH)))
         mem[ld_addr[IW-1:0]] <= ld_data;
   end

   // Credits cover both in-flight stages and buffered entries, so the FIFO never overflows.
   assign req_ready = !flush && (cnt < CW'(FIFO_DEPTH));
   assign acc       = req_valid && req_ready;
   assign pop       = !fifo_empty && resp_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt <= '0;
      else if (flush) cnt <= '0;
      else            cnt <= cnt + CW'(acc) - CW'(pop);
   end

   always_comb begin
      lane_idx      = '0;
      new_ent.addr  = req_addr;
      new_ent.fault = imem_classify(req_addr, DEPTH, FETCH_WIDTH);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         lane_idx         = req_addr[2 +: IW] + IW'(i);
         new_ent.instr[i] = (new_ent.fault == FAULT_NONE) ? mem[lane_idx] : NOP_INSTR;
      end
   end

   // The FIFO register itself is the final stage, so only LATENCY-1 pipe registers precede it.
   if (LATENCY == 1) begin : g_pipe0
      assign push_vld = acc;
      assign push_ent = new_ent;
   end else begin : g_pipe
      logic [LATENCY-2:0] vld_pipe;
      resp_t              ent_pipe [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_pipe <= '0;
         end else if (flush) begin
            vld_pipe <= '0;
         end else begin
            vld_pipe[0] <= acc;
            for (int k = 1; k < LATENCY - 1; k++) vld_pipe[k] <= vld_pipe[k-1];
         end
      end

      always_ff @(posedge clk) begin
         ent_pipe[0] <= new_ent;
         for (int k = 1; k < LATENCY - 1; k++) ent_pipe[k] <= ent_pipe[k-1];
      end

      assign push_vld = vld_pipe[LATENCY-2];
      assign push_ent = ent_pipe[LATENCY-2];
   end

   imem_resp_fifo #(
      .entry_t (resp_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push_vld),
      .pop   (pop),
      .din   (push_ent),
      .empty (fifo_empty),
      .head  (head)
   );

   // An empty FIFO presents the idle pattern rather than stale storage.
   assign resp_valid = !fifo_empty;
   assign resp_addr  = fifo_empty ? '0 : head.addr;
   assign resp_instr = fifo_empty ? {FETCH_WIDTH{NOP_INSTR}} : head.instr;
   assign resp_fault = fifo_empty ? FAULT_NONE : head.fault;

endmodule
